uart_rx_fifo: RTL and testbench

- Receive-side buffer between the UART receiver and the pipeline's UART control logic in the execute stage.
- Captures bytes the receiver presents and holds them in a first-word-fall-through FIFO.
- Presents the head byte as UARTDataOut / DataOutValid, which are the inputs the control unit samples on a UART-data load.
- Decouples software polling rate from line rate; counts and flags bytes dropped when the buffer is full.

---
 rtl/uart_rx_fifo_pkg.sv | 11 +
 rtl/sync_fifo_fwft.sv | 58 +++++
 rtl/uart_rx_fifo.sv | 61 ++++++
 tb/tb_uart_rx_fifo.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART definitions: MMIO map seen by the control unit and the receive buffer depth.
// No logic; constants only.
package uart_rx_fifo_pkg;

  localparam logic [31:0] UART_STATUS_ADDR  = 32'hFFFF_0000;
  localparam logic [31:0] UART_RX_DATA_ADDR = 32'hFFFF_0004;
  localparam logic [31:0] UART_TX_DATA_ADDR = 32'hFFFF_0008;

  localparam int UART_RX_DEPTH = 8;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Generic first-word-fall-through FIFO; head visible one cycle after write, zero-bubble streaming.
// Push while full is refused unless a pop frees the slot in the same cycle; pop while empty is ignored.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rd_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      cnt;
  logic             pop_ok;
  logic             push_ok;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  assign rd_dat = mem[rd_ptr];
  assign count  = cnt;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is deliberately not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push_ok) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: FWFT byte FIFO, head valid one cycle after capture, zero bubbles under continuous pop.
// The receiver cannot be stalled, so bytes arriving while full are dropped, counted and flagged.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH = UART_RX_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   flush,
  input  logic                   DataOutReady,
  output logic [7:0]             UARTDataOut,
  output logic                   DataOutValid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   overflow,
  output logic [7:0]             drop_count,
  input  logic                   clear_ovf
);

  logic empty;
  logic pop;
  logic drop;

  sync_fifo_fwft #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (rx_valid),
    .wr_dat (rx_data),
    .pop    (DataOutReady),
    .flush  (flush),
    .rd_dat (UARTDataOut),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  assign DataOutValid = ~empty;
  assign pop          = DataOutReady & DataOutValid;
  // A byte discarded by flush is intentional, not an overrun.
  assign drop         = rx_valid & full & ~pop & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else if (clear_ovf) begin
      overflow   <= drop;
      drop_count <= {7'd0, drop};
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model, pops checked against the scoreboard.
module tb_uart_rx_fifo;

  localparam int DEPTH = 8;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       flush;
  logic       DataOutReady;
  logic [7:0] UARTDataOut;
  logic       DataOutValid;
  logic [3:0] count;
  logic       full;
  logic       overflow;
  logic [7:0] drop_count;
  logic       clear_ovf;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .flush        (flush),
    .DataOutReady (DataOutReady),
    .UARTDataOut  (UARTDataOut),
    .DataOutValid (DataOutValid),
    .count        (count),
    .full         (full),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .clear_ovf    (clear_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] sb_q [$];
  logic       m_ovf;
  int         m_drops;
  int         n_checks;
  int         n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, update the model at the falling edge, check state after the rising edge.
  task automatic cycle(input logic r, input logic rv, input logic [7:0] d,
                       input logic rdy, input logic fl, input logic clr);
    logic was_full;
    logic do_pop;
    logic drop;
    rst = r; rx_valid = rv; rx_data = d; DataOutReady = rdy; flush = fl; clear_ovf = clr;
    @(negedge clk);
    drop = 1'b0;
    if (r) begin
      sb_q.delete();
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      if (fl) begin
        sb_q.delete();
      end else begin
        was_full = (sb_q.size() == DEPTH);
        do_pop   = rdy && (sb_q.size() > 0);
        if (do_pop) check_eq("pop_data", {24'd0, UARTDataOut}, {24'd0, sb_q.pop_front()});
        if (rv && (!was_full || do_pop)) sb_q.push_back(d);
        drop = rv && was_full && !do_pop;
      end
      if (clr) begin
        m_ovf   = drop;
        m_drops = drop ? 1 : 0;
      end else if (drop) begin
        m_ovf = 1'b1;
        if (m_drops < 255) m_drops++;
      end
    end
    @(posedge clk);
    #1;
    check_eq("count",      {28'd0, count},        sb_q.size());
    check_eq("valid",      {31'd0, DataOutValid}, {31'd0, sb_q.size() > 0});
    check_eq("full",       {31'd0, full},         {31'd0, sb_q.size() == DEPTH});
    check_eq("overflow",   {31'd0, overflow},     {31'd0, m_ovf});
    check_eq("drop_count", {24'd0, drop_count},   m_drops);
    if (sb_q.size() > 0) check_eq("head", {24'd0, UARTDataOut}, {24'd0, sb_q[0]});
  endtask

  task automatic push_b(input logic [7:0] d);
    cycle(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_b();
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_ovf    = 1'b0;
    m_drops  = 0;

    // Reset
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check_eq("rst_count", {28'd0, count}, 32'd0);

    // Single byte in and out
    push_b(8'h41);
    check_eq("t1_head",  {24'd0, UARTDataOut}, 32'h41);
    check_eq("t1_count", {28'd0, count},       32'd1);
    pop_b();
    check_eq("t1_valid", {31'd0, DataOutValid}, 32'd0);

    // Fill, then drain back-to-back; pointers wrap
    for (int i = 0; i < DEPTH; i++) push_b(8'(i));
    check_eq("t2_full",  {31'd0, full},  32'd1);
    check_eq("t2_count", {28'd0, count}, 32'd8);
    for (int i = 0; i < DEPTH; i++) pop_b();

    // Drops while full preserve oldest data
    for (int i = 0; i < DEPTH; i++) push_b(8'h10 + 8'(i));
    push_b(8'hAA);
    push_b(8'hBB);
    check_eq("t3_ovf",   {31'd0, overflow},    32'd1);
    check_eq("t3_drops", {24'd0, drop_count},  32'd2);
    check_eq("t3_head",  {24'd0, UARTDataOut}, 32'h10);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check_eq("t3_clr_ovf",   {31'd0, overflow},   32'd0);
    check_eq("t3_clr_drops", {24'd0, drop_count}, 32'd0);

    // Push and pop together while full
    cycle(1'b0, 1'b1, 8'hCC, 1'b1, 1'b0, 1'b0);
    check_eq("t4_count", {28'd0, count},      32'd8);
    check_eq("t4_drops", {24'd0, drop_count}, 32'd0);
    for (int i = 0; i < DEPTH - 1; i++) pop_b();
    check_eq("t4_last", {24'd0, UARTDataOut}, 32'hCC);
    pop_b();

    // clear_ovf coinciding with a drop, then saturation
    for (int i = 0; i < DEPTH; i++) push_b(8'h20 + 8'(i));
    cycle(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    check_eq("clr_drop_ovf",   {31'd0, overflow},   32'd1);
    check_eq("clr_drop_count", {24'd0, drop_count}, 32'd1);
    for (int i = 0; i < 260; i++) push_b(8'(i));
    check_eq("sat_drops", {24'd0, drop_count}, 32'd255);

    // Flush while full with a concurrent byte: no drop counted
    cycle(1'b0, 1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    check_eq("flush_full_count", {28'd0, count},      32'd0);
    check_eq("flush_full_drops", {24'd0, drop_count}, 32'd255);

    // Empty: simultaneous push and ready -> push only
    cycle(1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    check_eq("t5_count", {28'd0, count},       32'd1);
    check_eq("t5_head",  {24'd0, UARTDataOut}, 32'h55);
    cycle(1'b0, 1'b1, 8'h66, 1'b0, 1'b1, 1'b0);
    check_eq("t5_flush_valid", {31'd0, DataOutValid}, 32'd0);
    check_eq("t5_flush_drops", {24'd0, drop_count},   32'd255);

    // Reset mid-stream with a concurrent byte
    push_b(8'h01);
    push_b(8'h02);
    push_b(8'h03);
    cycle(1'b1, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0);
    check_eq("t6_count", {28'd0, count},        32'd0);
    check_eq("t6_ovf",   {31'd0, overflow},     32'd0);
    check_eq("t6_drops", {24'd0, drop_count},   32'd0);
    check_eq("t6_valid", {31'd0, DataOutValid}, 32'd0);

    // Operational after reset
    push_b(8'h99);
    check_eq("post_rst_head", {24'd0, UARTDataOut}, 32'h99);
    pop_b();
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
